// File: rtl/bicycle_pkg.sv
// Shared types and constants for the bicycle computer display path.
package bicycle_pkg;

  typedef enum logic [1:0] {
    MODE_DAY = 2'd0,
    MODE_AVS = 2'd1,
    MODE_TIM = 2'd2,
    MODE_MAX = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONV_UP = 2'd1,
    CONV_LO = 2'd2
  } sched_t;

  localparam logic [7:0]  ASCII_ZERO  = 8'd48;
  localparam logic [7:0]  ASCII_SPACE = 8'd32;
  localparam logic [13:0] MAX_LOWER   = 14'd9999;

  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    return ASCII_ZERO + {4'd0, d};
  endfunction

  function automatic mode_t next_mode(input mode_t m);
    return mode_t'(m + 2'd1);
  endfunction

endpackage

// File: rtl/display_flash_timer.sv
// Refresh tick generator plus 3-phase one-hot rotator; flash_phase is the third phase.
module display_flash_timer #(
  parameter int REFRESH_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  output logic tick,
  output logic flash_phase
);

  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    onehot;

  assign tick        = (cnt == CNT_LAST);
  assign flash_phase = onehot[2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      onehot <= 3'b001;
    end else if (tick) begin
      cnt    <= '0;
      onehot <= {onehot[1:0], onehot[2]};
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_sequencer.sv
// Display controller: mode FSM, shared BCD converter scheduler, indicators and overspeed flash.
// Build option LEADING_BLANK_EN blanks leading zeros of the lower readout.
module display_sequencer
  import bicycle_pkg::*;
#(
  parameter int F_CLK          = 2048,
  parameter int REFRESH_CYCLES = F_CLK / 2,
  parameter int CVT_TIMEOUT    = 64,
  parameter int FLASH_SPEED    = 65
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mode,
  input  logic [6:0]  speed,
  input  logic [13:0] day_dist,
  input  logic [13:0] avg_speed,
  input  logic [13:0] tim_value,
  input  logic [6:0]  max_speed,
  output logic        cvt_start,
  output logic [13:0] cvt_bin,
  input  logic        cvt_done,
  input  logic [15:0] cvt_bcd,
  output logic        cvt_err,
  output logic        DAY,
  output logic        AVS,
  output logic        TIM,
  output logic        MAX,
  output logic        col,
  output logic        point,
  output logic [7:0]  upper10,
  output logic [7:0]  upper01,
  output logic [7:0]  lower1000,
  output logic [7:0]  lower0100,
  output logic [7:0]  lower0010,
  output logic [7:0]  lower0001
);

  localparam int TW = (CVT_TIMEOUT > 1) ? $clog2(CVT_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(CVT_TIMEOUT - 1);

  sched_t        state_q, state_d;
  mode_t         mode_q, mode_n, tag_q;
  logic          day_q, avs_q, tim_q, max_q, point_q, col_q;
  logic          up_pend, lo_pend, mode_dirty, rr_up;
  logic [TW-1:0] tmo;
  logic          tick, flash_phase, flash;
  logic          up_req, lo_req, go_up, go_lo, wr_up, wr_lo, timeout;
  logic [13:0]   lo_val, lo_bin, up_bin;
  logic [6:0]    disp_speed;
  logic          blank3, blank2, blank1;

  display_flash_timer #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_flash (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .flash_phase (flash_phase)
  );

  // A tick arriving while idle is served at once rather than a cycle later.
  assign up_req = up_pend | tick;
  assign lo_req = lo_pend | tick;
  assign mode_n = next_mode(mode_q);

  always_comb begin
    lo_val = day_dist;
    case (mode_q)
      MODE_DAY: lo_val = day_dist;
      MODE_AVS: lo_val = avg_speed;
      MODE_TIM: lo_val = tim_value;
      default:  lo_val = {7'd0, max_speed};
    endcase
  end

  assign lo_bin = (lo_val > MAX_LOWER) ? MAX_LOWER : lo_val;
  assign up_bin = (speed > 7'd99) ? 14'd99 : {7'd0, speed};

  always_comb begin
    state_d = state_q;
    go_up   = 1'b0;
    go_lo   = 1'b0;
    wr_up   = 1'b0;
    wr_lo   = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (mode_dirty) begin
          go_lo = 1'b1;
        end else if (up_req && lo_req) begin
          go_up = rr_up;
          go_lo = !rr_up;
        end else begin
          go_up = up_req;
          go_lo = lo_req;
        end
        if (go_up)      state_d = CONV_UP;
        else if (go_lo) state_d = CONV_LO;
      end
      CONV_UP: begin
        if (cvt_done) begin
          wr_up   = 1'b1;
          state_d = IDLE;
        end else if (tmo == TMO_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      CONV_LO: begin
        if (cvt_done) begin
          // A result for a mode we have already left is dropped; lo_pend stays set.
          wr_lo   = (tag_q == mode_q);
          state_d = IDLE;
        end else if (tmo == TMO_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
`ifdef LEADING_BLANK_EN
    blank3 = (cvt_bcd[15:12] == 4'd0);
    blank2 = blank3 && (cvt_bcd[11:8] == 4'd0);
    blank1 = blank2 && (cvt_bcd[7:4] == 4'd0) && !point_q;
`else
    blank3 = 1'b0;
    blank2 = 1'b0;
    blank1 = 1'b0;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q     <= MODE_DAY;
      tag_q      <= MODE_DAY;
      day_q      <= 1'b1;
      avs_q      <= 1'b0;
      tim_q      <= 1'b0;
      max_q      <= 1'b0;
      point_q    <= 1'b1;
      col_q      <= 1'b0;
      cvt_start  <= 1'b0;
      cvt_bin    <= '0;
      cvt_err    <= 1'b0;
      up_pend    <= 1'b0;
      lo_pend    <= 1'b0;
      mode_dirty <= 1'b0;
      rr_up      <= 1'b1;
      tmo        <= '0;
      upper10    <= ASCII_ZERO;
      upper01    <= ASCII_ZERO;
      lower1000  <= ASCII_ZERO;
      lower0100  <= ASCII_ZERO;
      lower0010  <= ASCII_ZERO;
      lower0001  <= ASCII_ZERO;
    end else begin
      cvt_start <= go_up | go_lo;
      if (go_up) begin
        cvt_bin <= up_bin;
      end else if (go_lo) begin
        cvt_bin <= lo_bin;
        tag_q   <= mode_q;
      end
      if (go_up | go_lo) rr_up <= go_lo;

      if (state_q == IDLE) tmo <= '0;
      else                 tmo <= tmo + 1'b1;
      if (timeout) cvt_err <= 1'b1;

      // Set wins over clear so a coinciding request is never lost.
      up_pend    <= tick | (up_pend & ~wr_up);
      lo_pend    <= tick | mode | (lo_pend & ~wr_lo);
      mode_dirty <= mode | (mode_dirty & ~wr_lo);

      if (mode) begin
        mode_q  <= mode_n;
        day_q   <= (mode_n == MODE_DAY);
        avs_q   <= (mode_n == MODE_AVS);
        tim_q   <= (mode_n == MODE_TIM);
        max_q   <= (mode_n == MODE_MAX);
        point_q <= (mode_n == MODE_DAY) || (mode_n == MODE_AVS);
        col_q   <= (mode_n == MODE_TIM);
      end

      if (wr_up) begin
        upper10 <= to_ascii(cvt_bcd[7:4]);
        upper01 <= to_ascii(cvt_bcd[3:0]);
      end
      if (wr_lo) begin
        lower1000 <= blank3 ? ASCII_SPACE : to_ascii(cvt_bcd[15:12]);
        lower0100 <= blank2 ? ASCII_SPACE : to_ascii(cvt_bcd[11:8]);
        lower0010 <= blank1 ? ASCII_SPACE : to_ascii(cvt_bcd[7:4]);
        lower0001 <= to_ascii(cvt_bcd[3:0]);
      end
    end
  end

  // Flash follows what the rider sees, hence the upper digit registers.
  assign disp_speed = ({3'd0, upper10[3:0]} * 7'd10) + {3'd0, upper01[3:0]};
  assign flash      = flash_phase & (disp_speed > 7'(FLASH_SPEED));

  assign DAY   = day_q | flash;
  assign AVS   = avs_q | flash;
  assign TIM   = tim_q | flash;
  assign MAX   = max_q | flash;
  assign point = point_q;
  assign col   = col_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Directed bench for display_sequencer; the bench also plays the external BCD converter.
module tb_display_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mode = 1'b0;
  logic [6:0]  speed = 7'd42;
  logic [13:0] day_dist = 14'd1234;
  logic [13:0] avg_speed = 14'd250;
  logic [13:0] tim_value = 14'd512;
  logic [6:0]  max_speed = 7'd55;
  logic        cvt_start;
  logic [13:0] cvt_bin;
  logic        cvt_done = 1'b0;
  logic [15:0] cvt_bcd = '0;
  logic        cvt_err;
  logic        DAY, AVS, TIM, MAX, col, point;
  logic [7:0]  upper10, upper01, lower1000, lower0100, lower0010, lower0001;

  int          checks = 0;
  int          failures = 0;
  int          cd = 0;
  logic [13:0] svc_bin = '0;

  always #5 clock = ~clock;

  display_sequencer dut (
    .clock(clock), .reset(reset), .mode(mode), .speed(speed),
    .day_dist(day_dist), .avg_speed(avg_speed), .tim_value(tim_value), .max_speed(max_speed),
    .cvt_start(cvt_start), .cvt_bin(cvt_bin), .cvt_done(cvt_done), .cvt_bcd(cvt_bcd),
    .cvt_err(cvt_err), .DAY(DAY), .AVS(AVS), .TIM(TIM), .MAX(MAX), .col(col), .point(point),
    .upper10(upper10), .upper01(upper01), .lower1000(lower1000), .lower0100(lower0100),
    .lower0010(lower0010), .lower0001(lower0001)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; mode = 1'b0; cvt_done = 1'b0; cvt_bcd = '0; cd = 0;
    step(); step();
    reset = 1'b1;
  endtask

  task automatic wait_start(input int budget, output int n);
    n = -1;
    for (int i = 0; i <= budget; i++) begin
      if (cvt_start) begin
        n = i;
        break;
      end
      step();
    end
  endtask

  function automatic logic [15:0] bin2bcd(input logic [13:0] b);
    int v;
    v = int'(b);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Converter stand-in with a latency of 3 cycles after cvt_start.
  task automatic conv_service();
    cvt_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        cvt_done = 1'b1;
        cvt_bcd  = bin2bcd(svc_bin);
      end
    end
    if (cvt_start) begin
      cd = 3;
      svc_bin = cvt_bin;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    checks++; if ({upper10, upper01, lower1000, lower0100, lower0010, lower0001} !== {6{8'h30}}) begin
      failures++; $display("FAIL reset_digits: got %h want all 30", {upper10, upper01, lower1000, lower0100, lower0010, lower0001}); end
    checks++; if ({DAY, AVS, TIM, MAX} !== 4'b1000) begin
      failures++; $display("FAIL reset_leds: got %b want 1000", {DAY, AVS, TIM, MAX}); end
    checks++; if ({point, col} !== 2'b10) begin
      failures++; $display("FAIL reset_point_col: got %b want 10", {point, col}); end
    checks++; if ({cvt_start, cvt_err} !== 2'b00) begin
      failures++; $display("FAIL reset_cvt: got %b want 00", {cvt_start, cvt_err}); end
    reset = 1'b1;
  endtask

  task automatic test_first_tick();
    int early = 0;
    for (int k = 1; k <= 1023; k++) begin
      step();
      if (cvt_start) early++;
    end
    checks++; if (early != 0) begin
      failures++; $display("FAIL early_start: got %0d starts want 0", early); end
    step();
    checks++; if (cvt_start !== 1'b1) begin
      failures++; $display("FAIL first_start: got %b want 1", cvt_start); end
    checks++; if (cvt_bin !== 14'd42) begin
      failures++; $display("FAIL first_bin: got %0d want 42", cvt_bin); end
  endtask

  task automatic test_upper_lower();
    int n;
    step();
    checks++; if (cvt_start !== 1'b0) begin
      failures++; $display("FAIL start_width: got %b want 0", cvt_start); end
    repeat (19) step();
    cvt_done = 1'b1; cvt_bcd = 16'h0042;
    checks++; if (upper10 !== 8'h30) begin
      failures++; $display("FAIL upper_early: got %h want 30", upper10); end
    step();
    cvt_done = 1'b0;
    checks++; if ({upper10, upper01} !== 16'h3432) begin
      failures++; $display("FAIL upper_42: got %h want 3432", {upper10, upper01}); end
    checks++; if (lower0001 !== 8'h30) begin
      failures++; $display("FAIL lower_not_yet: got %h want 30", lower0001); end
    wait_start(5, n);
    checks++; if (n != 1) begin
      failures++; $display("FAIL lower_start_delay: got %0d want 1", n); end
    checks++; if (cvt_bin !== 14'd1234) begin
      failures++; $display("FAIL lower_bin: got %0d want 1234", cvt_bin); end
    repeat (20) step();
    cvt_done = 1'b1; cvt_bcd = 16'h1234;
    step();
    cvt_done = 1'b0;
    checks++; if ({lower1000, lower0100, lower0010, lower0001} !== 32'h31323334) begin
      failures++; $display("FAIL lower_1234: got %h want 31323334", {lower1000, lower0100, lower0010, lower0001}); end
  endtask

  task automatic test_mode_switch();
    logic [31:0] want;
    int n;
    speed = 7'd42; avg_speed = 14'd250; tim_value = 14'd512;
    do_reset();
    repeat (1020) step();
    mode = 1'b1;
    step();
    mode = 1'b0;
    checks++; if ({DAY, AVS, TIM, MAX, point, col} !== 6'b010010) begin
      failures++; $display("FAIL avs_leds: got %b want 010010", {DAY, AVS, TIM, MAX, point, col}); end
    step();
    checks++; if ({cvt_start, cvt_bin} !== {1'b1, 14'd250}) begin
      failures++; $display("FAIL avs_start: got %b/%0d want 1/250", cvt_start, cvt_bin); end
    mode = 1'b1;
    step();
    mode = 1'b0;
    checks++; if ({DAY, AVS, TIM, MAX, point, col} !== 6'b001001) begin
      failures++; $display("FAIL tim_leds: got %b want 001001", {DAY, AVS, TIM, MAX, point, col}); end
    step(); step();
    cvt_done = 1'b1; cvt_bcd = 16'h0250;
    step();
    cvt_done = 1'b0;
    checks++; if ({lower0100, lower0010} !== 16'h3030) begin
      failures++; $display("FAIL stale_discard: got %h want 3030", {lower0100, lower0010}); end
    wait_start(3, n);
    checks++; if (n != 1) begin
      failures++; $display("FAIL reconvert_delay: got %0d want 1", n); end
    checks++; if (cvt_bin !== 14'd512) begin
      failures++; $display("FAIL reconvert_bin: got %0d want 512", cvt_bin); end
    repeat (4) step();
    cvt_done = 1'b1; cvt_bcd = 16'h0512;
    step();
    cvt_done = 1'b0;
`ifdef LEADING_BLANK_EN
    want = 32'h20353132;
`else
    want = 32'h30353132;
`endif
    checks++; if ({lower1000, lower0100, lower0010, lower0001} !== want) begin
      failures++; $display("FAIL tim_0512: got %h want %h", {lower1000, lower0100, lower0010, lower0001}, want); end
    wait_start(3, n);
    checks++; if (n != 1 || cvt_bin !== 14'd42) begin
      failures++; $display("FAIL upper_after_lower: got %0d/%0d want 1/42", n, cvt_bin); end
    repeat (2) step();
    cvt_done = 1'b1; cvt_bcd = 16'h0042;
    step();
    cvt_done = 1'b0;
  endtask

  task automatic test_flash();
    int all_on = 0, first_on = -1, late_on = 0, day_off = 0, extra_on = 0;
    speed = 7'd70; day_dist = 14'd1234;
    do_reset();
    for (int k = 1; k <= 6143; k++) begin
      step(); conv_service();
      if (!DAY) day_off++;
      if (DAY && AVS && TIM && MAX) begin
        all_on++;
        if (first_on < 0) first_on = k;
        if (k >= 3072) late_on++;
      end
    end
    checks++; if (all_on != 2048) begin
      failures++; $display("FAIL flash_total: got %0d want 2048", all_on); end
    checks++; if (first_on != 2048) begin
      failures++; $display("FAIL flash_first: got %0d want 2048", first_on); end
    checks++; if (late_on != 1024) begin
      failures++; $display("FAIL flash_period: got %0d want 1024", late_on); end
    speed = 7'd65;
    for (int k = 6144; k <= 9300; k++) begin
      step(); conv_service();
      if (!DAY) day_off++;
      if (k >= 6200 && (AVS || TIM || MAX)) extra_on++;
    end
    checks++; if (extra_on != 0) begin
      failures++; $display("FAIL flash_at_65: got %0d lit cycles want 0", extra_on); end
    checks++; if (day_off != 0) begin
      failures++; $display("FAIL day_led_off: got %0d cycles want 0", day_off); end
    checks++; if ({upper10, upper01} !== 16'h3635) begin
      failures++; $display("FAIL upper_65: got %h want 3635", {upper10, upper01}); end
    checks++; if (cvt_err !== 1'b0) begin
      failures++; $display("FAIL err_clean: got %b want 0", cvt_err); end
  endtask

  task automatic test_timeout();
    int n;
    logic [13:0] first_bin, other_bin;
    speed = 7'd100; day_dist = 14'd15000; cvt_done = 1'b0;
    wait_start(1200, n);
    checks++; if (n != 940) begin
      failures++; $display("FAIL tmo_start_at: got %0d want 940", n); end
    first_bin = cvt_bin;
    other_bin = (first_bin == 14'd99) ? 14'd9999 : 14'd99;
    checks++; if (first_bin !== 14'd99 && first_bin !== 14'd9999) begin
      failures++; $display("FAIL clamp_bin: got %0d want 99 or 9999", first_bin); end
    repeat (63) step();
    checks++; if (cvt_err !== 1'b0) begin
      failures++; $display("FAIL err_early: got %b want 0", cvt_err); end
    step();
    checks++; if ({cvt_err, cvt_start} !== 2'b10) begin
      failures++; $display("FAIL err_at_64: got %b want 10", {cvt_err, cvt_start}); end
    step();
    checks++; if ({cvt_start, cvt_bin} !== {1'b1, other_bin}) begin
      failures++; $display("FAIL retry: got %b/%0d want 1/%0d", cvt_start, cvt_bin, other_bin); end
    checks++; if ({upper10, upper01, lower1000, lower0001} !== 32'h36353134) begin
      failures++; $display("FAIL retained: got %h want 36353134", {upper10, upper01, lower1000, lower0001}); end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_upper_lower();
    test_mode_switch();
    test_flash();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
